reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_mp_if.sv | 28 ++
 rtl/reg_file_clr_fsm.sv | 66 ++++++
 rtl/reg_file_mp.sv | 69 ++++++
 tb/tb_reg_file_mp.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and clear-FSM state type for the register file
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - write/read/clear bus of the multi-port register file
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);

    logic                       clr;
    logic                       we;
    logic [ADDR_W-1:0]          waddr;
    logic [DATA_W-1:0]          wdata;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic                       busy;

    modport master (
        output clr, we, waddr, wdata, raddr,
        input  rdata, busy
    );

    modport slave (
        input  clr, we, waddr, wdata, raddr,
        output rdata, busy
    );

endinterface

// File: rtl/reg_file_clr_fsm.sv
// rtl/reg_file_clr_fsm.sv - clear sweep controller: walks every entry once, one per cycle
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // One extra bit keeps the terminal comparison away from a wrap to zero.
    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << ADDR_W) - 1);

    clr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter; reset lands in SWEEP so the array is scrubbed after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a new clr always restarts the sweep at entry 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                clr_we = 1'b1;
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q == SWEEP);
    assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with write-first bypass and clear sweep
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;

    reg_file_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy = busy;

    // Host writes are dropped during the sweep and, with ZERO_REG, to entry 0.
    assign wr_en = bus.we && !busy && !(ZERO_REG && (bus.waddr == '0));

    // Storage has no reset; the sweep is the only way contents return to zero.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

        // Read mux: busy masks everything, zero entry beats bypass, bypass beats storage.
        always_comb begin
            rd = mem[ra];
            if (busy) begin
                rd = '0;
            end else if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end else if (bus.we && (ra == bus.waddr)) begin
                rd = bus.wdata;
            end
        end

        assign bus.rdata[i*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (default and small parameter sets)
module tb_reg_file_mp;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
    reg_file_mp_if #(.DATA_W(8),  .ADDR_W(3), .NUM_RD(4)) bus1 ();

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b0)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model0 [32];
    logic [7:0]  model1 [8];
    logic [31:0] got;
    logic [31:0] e;

    task automatic drive_idle();
        bus0.clr = 0; bus0.we = 0; bus0.waddr = '0; bus0.wdata = '0; bus0.raddr = '0;
        bus1.clr = 0; bus1.we = 0; bus1.waddr = '0; bus1.wdata = '0; bus1.raddr = '0;
    endtask

    // Counts consecutive busy samples of each DUT starting now (just after a negedge).
    task automatic count_busy(output int c0, output int c1);
        bit d0 = 0;
        bit d1 = 0;
        c0 = 0;
        c1 = 0;
        for (int n = 0; n < 100 && !(d0 && d1); n++) begin
            #1;
            if (!d0) begin if (bus0.busy) c0++; else d0 = 1; end
            if (!d1) begin if (bus1.busy) c1++; else d1 = 1; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int c0, c1;
        drive_idle();
        bus0.raddr = {5'd9, 5'd4};
        bus1.raddr = {3'd7, 3'd5, 3'd3, 3'd1};
        rst_n = 0;
        repeat (3) @(negedge clk);
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        got = {31'd0, bus0.busy}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset busy0: got %h expected %h", got, e); end
        got = {31'd0, bus1.busy}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset busy1: got %h expected %h", got, e); end
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset rdata0: got %h expected %h", got, e); end
        got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset rdata1: got %h expected %h", got, e); end
        got = {bus1.rdata}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL reset u1 rdata: got %h expected %h", got, e); end
        @(negedge clk);
        rst_n = 1;
        exp_q.push_back(32'd32); exp_q.push_back(32'd8);
        count_busy(c0, c1);
        e = exp_q.pop_front(); vectors++;
        if (c0 !== int'(e)) begin miscompares++; $display("FAIL reset sweep len0: got %0d expected %0d", c0, e); end
        e = exp_q.pop_front(); vectors++;
        if (c1 !== int'(e)) begin miscompares++; $display("FAIL reset sweep len1: got %0d expected %0d", c1, e); end
        for (int a = 0; a < 32; a++) model0[a] = '0;
        for (int a = 0; a < 8; a++) model1[a] = '0;
        for (int a = 1; a < 32; a++) begin
            bus0.raddr = {5'(a), 5'(32 - a)};
            exp_q.push_back(model0[a]); exp_q.push_back(model0[32 - a]);
            #1;
            got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset read[%0d]: got %h expected %h", a, got, e); end
            got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL reset read[%0d]: got %h expected %h", 32 - a, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_write_read();
        bus0.we = 1; bus0.waddr = 5'd5; bus0.wdata = 32'hDEADBEEF; bus0.raddr = {5'd2, 5'd1};
        @(negedge clk);
        model0[5] = 32'hDEADBEEF;
        bus0.we = 0; bus0.raddr = {5'd5, 5'd5};
        exp_q.push_back(model0[5]); exp_q.push_back(model0[5]);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL write_read port0: got %h expected %h", got, e); end
        got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL write_read port1: got %h expected %h", got, e); end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        bus0.we = 1; bus0.waddr = 5'd6; bus0.wdata = 32'hA5A50006; bus0.raddr = '0;
        @(negedge clk);
        model0[6] = 32'hA5A50006;
        bus0.we = 1; bus0.waddr = 5'd7; bus0.wdata = 32'h12345678; bus0.raddr = {5'd6, 5'd7};
        exp_q.push_back(32'h12345678); exp_q.push_back(model0[6]);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL bypass port0: got %h expected %h", got, e); end
        got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL bypass port1 old: got %h expected %h", got, e); end
        @(negedge clk);
        model0[7] = 32'h12345678;
        bus0.we = 0;
        exp_q.push_back(model0[7]); exp_q.push_back(model0[6]);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL bypass stored7: got %h expected %h", got, e); end
        got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL bypass stored6: got %h expected %h", got, e); end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        bus0.we = 1; bus0.waddr = 5'd0; bus0.wdata = 32'hFFFFFFFF; bus0.raddr = {5'd0, 5'd0};
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL zero_reg write cycle p0: got %h expected %h", got, e); end
        got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL zero_reg write cycle p1: got %h expected %h", got, e); end
        @(negedge clk);
        bus0.we = 0;
        exp_q.push_back(32'd0);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL zero_reg after: got %h expected %h", got, e); end
        @(negedge clk);
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        for (int a = 1; a < 32; a++) begin
            bus0.we = 1; bus0.waddr = 5'(a); bus0.wdata = 32'(a);
            @(negedge clk);
            model0[a] = 32'(a);
        end
        bus0.we = 0; bus0.raddr = {5'd31, 5'd17};
        exp_q.push_back(model0[17]); exp_q.push_back(model0[31]);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL clear fill 17: got %h expected %h", got, e); end
        got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL clear fill 31: got %h expected %h", got, e); end
        @(negedge clk);
        // write and clr together: the write lands, then the sweep wipes it
        bus0.clr = 1; bus0.we = 1; bus0.waddr = 5'd3; bus0.wdata = 32'h33333333; bus0.raddr = {5'd3, 5'd3};
        exp_q.push_back(32'h33333333);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL clear same-cycle bypass: got %h expected %h", got, e); end
        @(negedge clk);
        bus0.clr = 0; bus0.we = 0;
        for (int n = 0; n < 200; n++) begin
            if (!bus0.busy) break;
            bus0.clr = (n == 10);
            bus0.we = 1;
            bus0.waddr = 5'($urandom_range(1, 31));
            bus0.wdata = $urandom;
            bus0.raddr = {bus0.waddr, bus0.waddr};
            exp_q.push_back(32'd0);
            #1;
            got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL clear busy read n=%0d: got %h expected %h", n, got, e); end
            busy_cnt++;
            @(negedge clk);
        end
        bus0.clr = 0; bus0.we = 0;
        exp_q.push_back(32'd43);
        e = exp_q.pop_front(); vectors++;
        if (busy_cnt !== int'(e)) begin miscompares++; $display("FAIL clear busy length: got %0d expected %0d", busy_cnt, e); end
        for (int a = 0; a < 32; a++) model0[a] = '0;
        for (int a = 0; a < 32; a++) begin
            bus0.raddr = {5'(31 - a), 5'(a)};
            exp_q.push_back(model0[a]); exp_q.push_back(model0[31 - a]);
            #1;
            got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL clear after[%0d]: got %h expected %h", a, got, e); end
            got = bus0.rdata[63:32]; e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL clear after[%0d]: got %h expected %h", 31 - a, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int c0, c1;
        bus0.we = 1; bus0.waddr = 5'd9; bus0.wdata = 32'h99990009;
        @(negedge clk);
        bus0.we = 0; bus0.clr = 1;
        @(negedge clk);
        bus0.clr = 0;
        repeat (5) @(negedge clk);
        rst_n = 0; bus0.raddr = {5'd9, 5'd9};
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        #1;
        got = {31'd0, bus0.busy}; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL midsweep reset busy: got %h expected %h", got, e); end
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL midsweep reset rdata: got %h expected %h", got, e); end
        @(negedge clk);
        rst_n = 1;
        exp_q.push_back(32'd32); exp_q.push_back(32'd8);
        count_busy(c0, c1);
        e = exp_q.pop_front(); vectors++;
        if (c0 !== int'(e)) begin miscompares++; $display("FAIL midsweep len0: got %0d expected %0d", c0, e); end
        e = exp_q.pop_front(); vectors++;
        if (c1 !== int'(e)) begin miscompares++; $display("FAIL midsweep len1: got %0d expected %0d", c1, e); end
        exp_q.push_back(32'd0);
        #1;
        got = bus0.rdata[31:0]; e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL midsweep entry9: got %h expected %h", got, e); end
        @(negedge clk);
    endtask

    task automatic test_params();
        logic [11:0] pats [4];
        logic [2:0]  a;
        pats[0] = {3'd7, 3'd5, 3'd3, 3'd0};
        pats[1] = {3'd2, 3'd2, 3'd1, 3'd0};
        pats[2] = {3'd4, 3'd6, 3'd7, 3'd3};
        pats[3] = {3'd0, 3'd5, 3'd1, 3'd6};
        bus1.raddr = pats[0];
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(model1[pats[0][i*3 +: 3]]));
        #1;
        for (int i = 0; i < 4; i++) begin
            got = 32'(bus1.rdata[i*8 +: 8]); e = exp_q.pop_front(); vectors++;
            if (got !== e) begin miscompares++; $display("FAIL params zero port%0d: got %h expected %h", i, got, e); end
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus1.we = 1; bus1.waddr = 3'(i); bus1.wdata = 8'(8'hC3 ^ (i * 37));
            @(negedge clk);
            model1[i] = 8'(8'hC3 ^ (i * 37));
        end
        bus1.we = 0;
        for (int p = 0; p < 4; p++) begin
            bus1.raddr = pats[p];
            for (int i = 0; i < 4; i++) begin
                a = pats[p][i*3 +: 3];
                exp_q.push_back(32'(model1[a]));
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                got = 32'(bus1.rdata[i*8 +: 8]); e = exp_q.pop_front(); vectors++;
                if (got !== e) begin miscompares++; $display("FAIL params pat%0d port%0d: got %h expected %h", p, i, got, e); end
            end
            @(negedge clk);
        end
        // entry 0 is a real register here, bypass included
        bus1.we = 1; bus1.waddr = 3'd0; bus1.wdata = 8'h5A; bus1.raddr = {3'd1, 3'd0, 3'd4, 3'd2};
        exp_q.push_back(32'h5A);
        #1;
        got = 32'(bus1.rdata[23:16]); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL params bypass0: got %h expected %h", got, e); end
        @(negedge clk);
        model1[0] = 8'h5A;
        bus1.we = 0;
        exp_q.push_back(32'(model1[0]));
        #1;
        got = 32'(bus1.rdata[23:16]); e = exp_q.pop_front(); vectors++;
        if (got !== e) begin miscompares++; $display("FAIL params entry0: got %h expected %h", got, e); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_sweep();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
